mmio_uart_fifo_io: RTL and testbench
====================================

Name: mmio_uart_fifo_io

Overview:
- Memory-mapped IO block for the RISC-V CPU, sitting beside the data memory on the load/store path.
- Wraps the on-chip `uart` with parametrised RX/TX FIFOs, status and occupancy registers, and sticky overflow flags.
- Also holds cycle and retired-instruction counters of parametrised width.
- Replaces the single-byte, unbuffered UART mapping with buffered, backpressure-safe access.

Parameters:
- CPU_CLOCK_FREQ, 50_000_000, clock frequency passed to `uart`.
- BAUD_RATE, 115200, baud rate passed to `uart`.
- BASE_ADDR, 32'h8000_0000, base of the register window; all offsets below are relative to it.
- RX_FIFO_DEPTH, 8, RX FIFO entries; must be a power of two, 2..256.
- TX_FIFO_DEPTH, 8, TX FIFO entries; must be a power of two, 2..256.
- CNT_WIDTH, 32, counter width, 8..32; counters are zero-extended on read.

Ports:
- clk  input  1  CPU clock.
- rst  input  1  synchronous, active-high reset.
- serial_in  input  1  UART RX line.
- serial_out  output  1  UART TX line.
- rd_en  input  1  CPU load to the IO window this cycle.
- rd_addr  input  32  load address.
- rd_data  output  32  load data, combinational from rd_addr.
- wr_en  input  1  CPU store to the IO window this cycle.
- wr_addr  input  32  store address.
- wr_data  input  32  store data.
- inst_retire  input  1  one pulse per retired instruction; the pipeline excludes bubbles.
- irq  output  1  interrupt request; see Optional Feature.

Behaviour:
- Register map (offset, access, content):
  - 0x00 R status: bit0 = tx_ready (TX not full), bit1 = rx_valid (RX not empty), bit2 = tx_empty, bit3 = rx_full, bit4 = rx_ovf, bit5 = tx_ovf.
  - 0x04 R rx data: {24'b0, head byte}; pops the RX FIFO. Returns 0 with no pop when RX is empty.
  - 0x08 W tx data: pushes wr_data[7:0] onto the TX FIFO.
  - 0x0C R occupancy: {7'b0, tx_count[8:0], 7'b0, rx_count[8:0]}.
  - 0x10 R cycle counter.
  - 0x14 R instruction counter.
  - 0x18 W any value clears both counters.
  - 0x1C W1C overflow flags: wr_data bit0 clears rx_ovf, bit1 clears tx_ovf.
  - Unmapped offsets read 0; writes to them are ignored.
- Read data is combinational. Side effects (pop, push, clear) take effect at the posedge of the access cycle, gated by rd_en/wr_en.
- RX path:
  - uart data_out_ready is tied to 1.
  - When data_out_valid is high: if the FIFO is not full, push; if full, drop the byte and set rx_ovf.
  - Simultaneous push and pop on a full FIFO is legal: count unchanged, no overflow.
  - Simultaneous push and pop on an empty FIFO: push only; read returns 0.
- TX path:
  - uart data_in = head byte; data_in_valid = !tx_empty.
  - Pop when data_in_valid && data_in_ready.
  - A store to 0x08 while full drops the byte and sets tx_ovf.
  - Push and pop in the same cycle is legal when full.
- FIFOs are circular buffers whose pointers wrap modulo depth. Count is held in a separate register, so depth = count is full and 0 is empty.
- Counters:
  - cycle increments every cycle; instr increments on inst_retire. Both wrap at 2^CNT_WIDTH.
  - A write to 0x18 in the same cycle as an increment leaves the counter at 0 (clear wins).
- Overflow flag set and W1C clear in the same cycle: set wins.
- Reset:
  - FIFOs empty with pointers 0; counters 0; ovf flags 0; irq 0.
  - serial_out idles high (via `uart` reset).
  - Reset mid-frame discards all FIFO contents; the in-flight TX byte is abandoned.

Optional Feature:
- Macro: MMIO_IO_IRQ_EN.
- With the macro defined:
  - Adds a control register at 0x20 (RW, reset 0): bit0 = rx_irq_en, bit1 = tx_irq_en.
  - irq is registered and equals (rx_irq_en && rx_valid) || (tx_irq_en && tx_empty) || rx_ovf || tx_ovf, one cycle after the condition.
- Without the macro:
  - irq is tied to 0.
  - 0x20 reads 0; writes to it are ignored.

Test Plan:
- Reset, then read 0x00 -> 32'h0000_0005 (tx_ready=1, tx_empty=1); 0x10 and 0x14 reads advance from 0.
- Serially inject 0x41, 0x42, 0x43, then read 0x0C -> rx_count=3. Three reads of 0x04 -> 0x41, 0x42, 0x43. A fourth read -> 0, and status bit1=0.
- With RX_FIFO_DEPTH=8, inject 9 bytes 0x10..0x18 -> rx_full=1 and rx_ovf=1. Drain -> 0x10..0x17. Write 0x1C with 1 -> rx_ovf=0.
- Store 0x55 then 0xAA to 0x08 -> serial_out carries both frames in order, each LSB-first at BAUD_RATE. Afterwards tx_empty=1.
- Store 9 bytes back-to-back to 0x08 (depth 8, UART busy) -> one byte dropped, tx_ovf=1. With the UART draining its first byte during the burst, no drop occurs.
- CNT_WIDTH=8: after 256 cycles the cycle counter wraps to 0. A write to 0x18 coinciding with inst_retire -> both counters read 0 the next cycle.
- MMIO_IO_IRQ_EN defined: write 0x20=1, inject one byte -> irq=1 one cycle after rx_valid. A read of 0x04 -> irq=0 on the following cycle.

Source files
------------

// File: rtl/mmio_uart_fifo_io_if.sv
// Load/store port between the CPU memory stage and the IO register window.
interface mmio_uart_fifo_io_if;
   logic        rd_en;
   logic [31:0] rd_addr;
   logic [31:0] rd_data;
   logic        wr_en;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;

   modport master (output rd_en, rd_addr, wr_en, wr_addr, wr_data, input rd_data);
   modport slave  (input rd_en, rd_addr, wr_en, wr_addr, wr_data, output rd_data);
endinterface

// File: rtl/mmio_uart_fifo_io.sv
// Buffered UART, status/occupancy and cycle/instret counters behind a small MMIO window.
// Optional registered interrupt output and control register at 0x20 under MMIO_IO_IRQ_EN.
module uart #(
   parameter int CLOCK_FREQ = 50_000_000,
   parameter int BAUD_RATE  = 115200
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       serial_in,
   output logic       serial_out,
   input  logic [7:0] data_in,
   input  logic       data_in_valid,
   output logic       data_in_ready,
   output logic [7:0] data_out,
   output logic       data_out_valid,
   input  logic       data_out_ready
);
   // state    | meaning
   // RX_IDLE  | line idle, waiting for a low level
   // RX_START | timing to the middle of the start bit
   // RX_DATA  | sampling 8 data bits LSB-first, one per bit period
   // RX_STOP  | sampling the stop bit; a high stop bit delivers the byte
   localparam int CPB  = (CLOCK_FREQ / BAUD_RATE > 0) ? CLOCK_FREQ / BAUD_RATE : 1;
   localparam int HALF = (CPB / 2 > 0) ? CPB / 2 - 1 : 0;
   localparam int TW   = $clog2(CPB + 1);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   logic          tx_busy;
   logic [9:0]    tx_shift;
   logic [3:0]    tx_bits;
   logic [TW-1:0] tx_tmr;

   assign data_in_ready = !tx_busy;
   assign serial_out    = tx_busy ? tx_shift[0] : 1'b1;

   always_ff @(posedge clk) begin
      if (reset) begin
         tx_busy  <= 1'b0;
         tx_shift <= '1;
         tx_bits  <= '0;
         tx_tmr   <= '0;
      end else if (!tx_busy) begin
         if (data_in_valid) begin
            tx_busy  <= 1'b1;
            tx_shift <= {1'b1, data_in, 1'b0};
            tx_bits  <= 4'd9;
            tx_tmr   <= TW'(CPB - 1);
         end
      end else if (tx_tmr == '0) begin
         if (tx_bits == '0) begin
            tx_busy <= 1'b0;
         end else begin
            tx_shift <= {1'b1, tx_shift[9:1]};
            tx_bits  <= tx_bits - 4'd1;
            tx_tmr   <= TW'(CPB - 1);
         end
      end else begin
         tx_tmr <= tx_tmr - TW'(1);
      end
   end

   rx_state_t     rx_state, rx_state_n;
   logic          rx_meta, rx_sync;
   logic [TW-1:0] rx_tmr, rx_tmr_n;
   logic [2:0]    rx_bits, rx_bits_n;
   logic [7:0]    rx_shift, rx_shift_n;
   logic          rx_valid, rx_valid_n;

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_meta  <= 1'b1;
         rx_sync  <= 1'b1;
         rx_state <= RX_IDLE;
         rx_tmr   <= '0;
         rx_bits  <= '0;
         rx_shift <= '0;
         rx_valid <= 1'b0;
      end else begin
         rx_meta  <= serial_in;
         rx_sync  <= rx_meta;
         rx_state <= rx_state_n;
         rx_tmr   <= rx_tmr_n;
         rx_bits  <= rx_bits_n;
         rx_shift <= rx_shift_n;
         rx_valid <= rx_valid_n;
      end
   end

   always_comb begin
      rx_state_n = rx_state;
      rx_tmr_n   = rx_tmr;
      rx_bits_n  = rx_bits;
      rx_shift_n = rx_shift;
      rx_valid_n = rx_valid && !data_out_ready;
      case (rx_state)
         RX_IDLE: begin
            if (!rx_sync) begin
               rx_state_n = RX_START;
               rx_tmr_n   = TW'(HALF);
            end
         end
         RX_START: begin
            if (rx_tmr != '0) begin
               rx_tmr_n = rx_tmr - TW'(1);
            end else if (!rx_sync) begin
               rx_state_n = RX_DATA;
               rx_tmr_n   = TW'(CPB - 1);
               rx_bits_n  = 3'd7;
            end else begin
               rx_state_n = RX_IDLE;  // glitch, not a start bit
            end
         end
         RX_DATA: begin
            if (rx_tmr != '0) begin
               rx_tmr_n = rx_tmr - TW'(1);
            end else begin
               rx_shift_n = {rx_sync, rx_shift[7:1]};
               rx_tmr_n   = TW'(CPB - 1);
               if (rx_bits == '0) rx_state_n = RX_STOP;
               else               rx_bits_n  = rx_bits - 3'd1;
            end
         end
         RX_STOP: begin
            if (rx_tmr != '0) begin
               rx_tmr_n = rx_tmr - TW'(1);
            end else begin
               rx_state_n = RX_IDLE;
               rx_valid_n = rx_sync;
            end
         end
         default: rx_state_n = RX_IDLE;
      endcase
   end

   assign data_out       = rx_shift;
   assign data_out_valid = rx_valid;
endmodule

module mmio_uart_fifo_io #(
   parameter int          CPU_CLOCK_FREQ = 50_000_000,
   parameter int          BAUD_RATE      = 115200,
   parameter logic [31:0] BASE_ADDR      = 32'h8000_0000,
   parameter int          RX_FIFO_DEPTH  = 8,
   parameter int          TX_FIFO_DEPTH  = 8,
   parameter int          CNT_WIDTH      = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                serial_in,
   output logic                serial_out,
   mmio_uart_fifo_io_if.slave  bus,
   input  logic                inst_retire,
   output logic                irq
);
   localparam int RAW = $clog2(RX_FIFO_DEPTH);
   localparam int TAW = $clog2(TX_FIFO_DEPTH);
   localparam logic [31:0] OFF_STATUS = 32'h00;
   localparam logic [31:0] OFF_RXDATA = 32'h04;
   localparam logic [31:0] OFF_TXDATA = 32'h08;
   localparam logic [31:0] OFF_OCC    = 32'h0C;
   localparam logic [31:0] OFF_CYCLE  = 32'h10;
   localparam logic [31:0] OFF_INSTR  = 32'h14;
   localparam logic [31:0] OFF_CNTCLR = 32'h18;
   localparam logic [31:0] OFF_OVFCLR = 32'h1C;

   logic [31:0] rd_off, wr_off;
   assign rd_off = bus.rd_addr - BASE_ADDR;
   assign wr_off = bus.wr_addr - BASE_ADDR;

   logic [7:0] uart_tx_data, uart_rx_data;
   logic       uart_tx_ready, uart_rx_valid;

   logic [7:0]     rx_mem [RX_FIFO_DEPTH];
   logic [RAW-1:0] rx_wr_ptr, rx_rd_ptr;
   logic [8:0]     rx_count;
   logic           rx_empty, rx_full, rx_push, rx_pop, rx_ovf;

   logic [7:0]     tx_mem [TX_FIFO_DEPTH];
   logic [TAW-1:0] tx_wr_ptr, tx_rd_ptr;
   logic [8:0]     tx_count;
   logic           tx_empty, tx_full, tx_push, tx_pop, tx_ovf, tx_store;

   logic [CNT_WIDTH-1:0] cycle_cnt, instr_cnt;
   logic                 cnt_clr, ovf_clr;

   assign rx_empty = (rx_count == 9'd0);
   assign rx_full  = (rx_count == 9'(RX_FIFO_DEPTH));
   assign tx_empty = (tx_count == 9'd0);
   assign tx_full  = (tx_count == 9'(TX_FIFO_DEPTH));

   // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
   assign rx_pop   = bus.rd_en && (rd_off == OFF_RXDATA) && !rx_empty;
   assign rx_push  = uart_rx_valid && (!rx_full || rx_pop);
   assign tx_store = bus.wr_en && (wr_off == OFF_TXDATA);
   assign tx_pop   = !tx_empty && uart_tx_ready;
   assign tx_push  = tx_store && (!tx_full || tx_pop);
   assign cnt_clr  = bus.wr_en && (wr_off == OFF_CNTCLR);
   assign ovf_clr  = bus.wr_en && (wr_off == OFF_OVFCLR);

   assign uart_tx_data = tx_mem[tx_rd_ptr];

   uart #(
      .CLOCK_FREQ (CPU_CLOCK_FREQ),
      .BAUD_RATE  (BAUD_RATE)
   ) u_uart (
      .clk            (clk),
      .reset          (rst),
      .serial_in      (serial_in),
      .serial_out     (serial_out),
      .data_in        (uart_tx_data),
      .data_in_valid  (!tx_empty),
      .data_in_ready  (uart_tx_ready),
      .data_out       (uart_rx_data),
      .data_out_valid (uart_rx_valid),
      .data_out_ready (1'b1)
   );

   always_ff @(posedge clk) begin
      if (rx_push) rx_mem[rx_wr_ptr] <= uart_rx_data;
      if (tx_push) tx_mem[tx_wr_ptr] <= bus.wr_data[7:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_wr_ptr <= '0;
         rx_rd_ptr <= '0;
         rx_count  <= '0;
         tx_wr_ptr <= '0;
         tx_rd_ptr <= '0;
         tx_count  <= '0;
      end else begin
         if (rx_push) rx_wr_ptr <= rx_wr_ptr + RAW'(1);
         if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + RAW'(1);
         if (rx_push && !rx_pop)      rx_count <= rx_count + 9'd1;
         else if (!rx_push && rx_pop) rx_count <= rx_count - 9'd1;
         if (tx_push) tx_wr_ptr <= tx_wr_ptr + TAW'(1);
         if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + TAW'(1);
         if (tx_push && !tx_pop)      tx_count <= tx_count + 9'd1;
         else if (!tx_push && tx_pop) tx_count <= tx_count - 9'd1;
      end
   end

   // Setting has priority over a W1C landing in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_ovf <= 1'b0;
         tx_ovf <= 1'b0;
      end else begin
         if (uart_rx_valid && rx_full && !rx_pop) rx_ovf <= 1'b1;
         else if (ovf_clr && bus.wr_data[0])      rx_ovf <= 1'b0;
         if (tx_store && tx_full && !tx_pop)      tx_ovf <= 1'b1;
         else if (ovf_clr && bus.wr_data[1])      tx_ovf <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || cnt_clr) begin
         cycle_cnt <= '0;
         instr_cnt <= '0;
      end else begin
         cycle_cnt <= cycle_cnt + CNT_WIDTH'(1);
         if (inst_retire) instr_cnt <= instr_cnt + CNT_WIDTH'(1);
      end
   end

`ifdef MMIO_IO_IRQ_EN
   localparam logic [31:0] OFF_CTRL = 32'h20;
   logic ctrl_wr, rx_irq_en, tx_irq_en, irq_q;
   assign ctrl_wr = bus.wr_en && (wr_off == OFF_CTRL);

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_irq_en <= 1'b0;
         tx_irq_en <= 1'b0;
         irq_q     <= 1'b0;
      end else begin
         if (ctrl_wr) begin
            rx_irq_en <= bus.wr_data[0];
            tx_irq_en <= bus.wr_data[1];
         end
         irq_q <= (rx_irq_en && !rx_empty) || (tx_irq_en && tx_empty) || rx_ovf || tx_ovf;
      end
   end
   assign irq = irq_q;
`else
   assign irq = 1'b0;
`endif

   logic [31:0] rd_mux;
   always_comb begin
      rd_mux = '0;
      case (rd_off)
         OFF_STATUS: rd_mux = {26'b0, tx_ovf, rx_ovf, rx_full, tx_empty, !rx_empty, !tx_full};
         OFF_RXDATA: rd_mux = rx_empty ? 32'h0 : {24'b0, rx_mem[rx_rd_ptr]};
         OFF_OCC:    rd_mux = {7'b0, tx_count, 7'b0, rx_count};
         OFF_CYCLE:  rd_mux = 32'(cycle_cnt);
         OFF_INSTR:  rd_mux = 32'(instr_cnt);
`ifdef MMIO_IO_IRQ_EN
         OFF_CTRL:   rd_mux = {30'b0, tx_irq_en, rx_irq_en};
`endif
         default:    rd_mux = '0;
      endcase
   end
   assign bus.rd_data = rd_mux;

   logic unused_wr_bits;
   assign unused_wr_bits = ^bus.wr_data[31:8];
endmodule

// File: tb/tb_mmio_uart_fifo_io.sv
// Directed bench for mmio_uart_fifo_io: serial RX driver, TX frame monitor, queue scoreboards.
`timescale 1ns/1ps
module tb_mmio_uart_fifo_io;
   localparam int          CLK_FREQ = 1_000_000;
   localparam int          BAUD     = 100_000;
   localparam int          CPB      = CLK_FREQ / BAUD;
   localparam int          DEPTH    = 8;
   localparam int          CW       = 8;
   localparam logic [31:0] BASE     = 32'h8000_0000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic serial_in = 1'b1;
   logic serial_out;
   logic inst_retire = 1'b0;
   logic irq;

   mmio_uart_fifo_io_if bus();

   mmio_uart_fifo_io #(
      .CPU_CLOCK_FREQ (CLK_FREQ),
      .BAUD_RATE      (BAUD),
      .BASE_ADDR      (BASE),
      .RX_FIFO_DEPTH  (DEPTH),
      .TX_FIFO_DEPTH  (DEPTH),
      .CNT_WIDTH      (CW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .serial_in   (serial_in),
      .serial_out  (serial_out),
      .bus         (bus),
      .inst_retire (inst_retire),
      .irq         (irq)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   logic [7:0] rx_exp[$];
   logic [7:0] tx_exp[$];
   logic mon_busy = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [7:0] off, output logic [31:0] d);
      bus.rd_en   = 1'b1;
      bus.rd_addr = BASE + 32'(off);
      @(negedge clk);
      d = bus.rd_data;
      @(posedge clk);
      #1;
      bus.rd_en = 1'b0;
   endtask

   task automatic rd_check(input string tag, input logic [7:0] off, input logic [31:0] exp);
      logic [31:0] d;
      rd(off, d);
      check(tag, d, exp);
   endtask

   task automatic wr(input logic [7:0] off, input logic [31:0] d);
      bus.wr_en   = 1'b1;
      bus.wr_addr = BASE + 32'(off);
      bus.wr_data = d;
      @(posedge clk);
      #1;
      bus.wr_en = 1'b0;
   endtask

   // Model: a byte lands in the RX FIFO only if there is room for it.
   task automatic send_byte(input logic [7:0] b);
      logic [9:0] fr;
      fr = {1'b1, b, 1'b0};
      if (rx_exp.size() < DEPTH) rx_exp.push_back(b);
      for (int i = 0; i < 10; i++) begin
         serial_in = fr[i];
         tick(CPB);
      end
      tick(3);
   endtask

   task automatic wait_tx_drain(input string tag);
      int i;
      i = 0;
      while ((tx_exp.size() != 0 || mon_busy) && i < 3000) begin
         tick(1);
         i++;
      end
      check(tag, 32'(tx_exp.size()) | 32'(mon_busy), 32'h0);
      tick(CPB);
   endtask

   initial begin : tx_monitor
      logic [7:0]  b;
      logic [31:0] e;
      @(negedge rst);
      forever begin
         @(negedge serial_out);
         mon_busy = 1'b1;
         repeat (CPB / 2) @(negedge clk);
         check("tx_start_bit", 32'(serial_out), 32'h0);
         for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            b[i] = serial_out;
         end
         repeat (CPB) @(negedge clk);
         check("tx_stop_bit", 32'(serial_out), 32'h1);
         if (tx_exp.size() == 0) e = 32'h100;
         else                    e = 32'(tx_exp.pop_front());
         check("tx_frame", 32'(b), e);
         mon_busy = 1'b0;
      end
   end

   initial begin : watchdog
      #500_000;
      $display("FAIL watchdog: simulation time limit reached, %0d vectors, %0d miscompares", n_vec, n_err);
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      bus.rd_en   = 1'b0;
      bus.rd_addr = '0;
      bus.wr_en   = 1'b0;
      bus.wr_addr = '0;
      bus.wr_data = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // reset state and counters advancing from 0
      rd_check("cycle_after_reset", 8'h10, 32'd0);
      rd_check("cycle_advance", 8'h10, 32'd1);
      rd_check("instr_after_reset", 8'h14, 32'd0);
      rd_check("reset_status", 8'h00, 32'h0000_0005);
      rd_check("reset_occupancy", 8'h0C, 32'h0);
      rd_check("unmapped_24", 8'h24, 32'h0);
      rd_check("ctrl_reset", 8'h20, 32'h0);
      check("irq_reset", 32'(irq), 32'h0);

      // three RX bytes then an empty read
      send_byte(8'h41);
      send_byte(8'h42);
      send_byte(8'h43);
      rd_check("rx_occupancy_3", 8'h0C, 32'h0000_0003);
      rd_check("rx_status_valid", 8'h00, 32'h0000_0007);
      for (int i = 0; i < 3; i++) rd_check("rx_data", 8'h04, 32'(rx_exp.pop_front()));
      rd_check("rx_empty_read", 8'h04, 32'h0);
      rd_check("rx_status_drained", 8'h00, 32'h0000_0005);

`ifdef MMIO_IO_IRQ_EN
      wr(8'h20, 32'h1);
      rd_check("ctrl_readback", 8'h20, 32'h1);
      send_byte(8'h5A);
      check("irq_rx_valid", 32'(irq), 32'h1);
      rd_check("irq_rx_data", 8'h04, 32'(rx_exp.pop_front()));
      check("irq_held_pop_cycle", 32'(irq), 32'h1);
      tick(1);
      check("irq_after_pop", 32'(irq), 32'h0);
      wr(8'h20, 32'h0);
`else
      wr(8'h20, 32'h3);
      rd_check("ctrl_ignored", 8'h20, 32'h0);
      send_byte(8'h5A);
      check("irq_tied_low", 32'(irq), 32'h0);
      rd_check("irq_rx_data", 8'h04, 32'(rx_exp.pop_front()));
      tick(1);
      check("irq_tied_low_pop", 32'(irq), 32'h0);
`endif

      // RX overflow: nine bytes into eight slots
      for (int i = 0; i < 9; i++) send_byte(8'(8'h10 + i));
      rd_check("rx_ovf_status", 8'h00, 32'h0000_001F);
      rd_check("rx_full_occupancy", 8'h0C, 32'h0000_0008);
      for (int i = 0; i < 8; i++) rd_check("rx_ovf_drain", 8'h04, 32'(rx_exp.pop_front()));
      rd_check("rx_ovf_sticky", 8'h00, 32'h0000_0015);
      wr(8'h1C, 32'h1);
      rd_check("rx_ovf_cleared", 8'h00, 32'h0000_0005);

      // two TX frames in order
      wr(8'h08, 32'h55);
      tx_exp.push_back(8'h55);
      wr(8'h08, 32'hAA);
      tx_exp.push_back(8'hAA);
      wait_tx_drain("tx_drain_two");
      rd_check("tx_idle_status", 8'h00, 32'h0000_0005);

      // TX burst with the UART already busy: the ninth store is dropped
      wr(8'h08, 32'h60);
      tx_exp.push_back(8'h60);
      tick(2);
      for (int i = 1; i <= 9; i++) begin
         wr(8'h08, 32'(8'h60 + i));
         if (i <= 8) tx_exp.push_back(8'(8'h60 + i));
      end
      rd_check("tx_ovf_full_status", 8'h00, 32'h0000_0020);
      rd_check("tx_full_occupancy", 8'h0C, 32'h0008_0000);
      wait_tx_drain("tx_drain_busy_burst");
      rd_check("tx_ovf_sticky", 8'h00, 32'h0000_0025);
      wr(8'h1C, 32'h2);
      rd_check("tx_ovf_cleared", 8'h00, 32'h0000_0005);

      // TX burst from idle: the UART takes the first byte, nothing dropped
      for (int i = 0; i < 9; i++) begin
         wr(8'h08, 32'(8'h70 + i));
         tx_exp.push_back(8'(8'h70 + i));
      end
      rd_check("tx_nodrop_status", 8'h00, 32'h0000_0000);
      rd_check("tx_nodrop_occupancy", 8'h0C, 32'h0008_0000);
      wait_tx_drain("tx_drain_idle_burst");
      rd_check("tx_nodrop_final", 8'h00, 32'h0000_0005);

      // counters: clear, wrap at 2^CW, instret, clear beats increment
      wr(8'h18, 32'h0);
      rd_check("cycle_cleared", 8'h10, 32'd0);
      tick(254);
      rd_check("cycle_255", 8'h10, 32'd255);
      rd_check("cycle_wrap", 8'h10, 32'd0);
      wr(8'h18, 32'h0);
      inst_retire = 1'b1;
      tick(3);
      inst_retire = 1'b0;
      rd_check("instr_count_3", 8'h14, 32'd3);
      inst_retire = 1'b1;
      wr(8'h18, 32'h0);
      inst_retire = 1'b0;
      rd_check("clear_wins_cycle", 8'h10, 32'd0);
      rd_check("clear_wins_instr", 8'h14, 32'd0);

      // reset discards buffered RX data
      send_byte(8'h31);
      send_byte(8'h32);
      rd_check("pre_reset_occupancy", 8'h0C, 32'h0000_0002);
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      rx_exp.delete();
      rd_check("post_reset_status", 8'h00, 32'h0000_0005);
      rd_check("post_reset_occupancy", 8'h0C, 32'h0);
      rd_check("post_reset_rx_read", 8'h04, 32'h0);
      check("post_reset_serial_out", 32'(serial_out), 32'h1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
